// File: rtl/mutidata_hs_rx.sv
// Destination endpoint of a 4-phase multi-bit CDC handshake, in the clk_o domain.
// Latency: req edge to out_vld is SYNC_STAGES+1 edges; ack follows acceptance by one edge.
// Backpressure: out_rdy low holds the word and out_vld indefinitely; ack waits for acceptance.
module mutidata_hs_rx #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk_o,
    input  logic             rst_o,
    input  logic             req_async,
    input  logic [DW-1:0]    din_async,
    input  logic             out_rdy,
    output logic             out_vld,
    output logic [DW-1:0]    dout,
    output logic             ack,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t               state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 req_s;

    // Level synchroniser for the source request; only the last stage is used.
    always_ff @(posedge clk_o or posedge rst_o) begin
        if (rst_o) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_async};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // Handshake FSM. din_async is sampled only once req_s is seen high, at which
    // point the source guarantees it has been stable for several clk_o cycles.
    // busy is kept as its own flop so the output has no decode logic after it.
    always_ff @(posedge clk_o or posedge rst_o) begin
        if (rst_o) begin
            state    <= IDLE;
            out_vld  <= 1'b0;
            dout     <= '0;
            ack      <= 1'b0;
            busy     <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= 1'b0;
                    if (req_s) begin
                        dout    <= din_async;
                        out_vld <= 1'b1;
                        busy    <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    // req_s dropping here is a source protocol error; the word is
                    // still delivered and ACK then exits on the next edge.
                    if (out_rdy) begin
                        out_vld  <= 1'b0;
                        ack      <= 1'b1;
                        xfer_cnt <= xfer_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        state    <= ACK;
                    end
                end
                ACK: begin
                    // A request still high here belongs to the word just delivered.
                    if (!req_s) begin
                        ack   <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    out_vld <= 1'b0;
                    ack     <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
